noc_packetizer: RTL and testbench
=================================

// Module: noc_packetizer
// PURPOSE
//  Upstream feeder for the NoC store stage. Accepts a byte stream grouped into messages.
//  Converts each byte into one 13-bit NoC packet: {eop, payload[7:0], type[1:0], dest[1:0]}.
//  Packets queue in a small FWFT FIFO, which drives the NoC src_valid/src_ready handshake.
//  Also enforces destination legality and a maximum message length.
// PARAMETERS
//  DEPTH    4   FIFO entries (power of 2, >=2)
//  MAX_LEN  8   max bytes per message (>=2); the byte at MAX_LEN is force-terminated
//  CW       $clog2(DEPTH+1)  width of fifo_count (derived, not overridable)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low (reset==0 resets all state)
//  in_valid    in   1   upstream byte valid
//  in_ready    out  1   byte accepted when in_valid&in_ready
//  in_dest     in   2   destination; sampled on first beat of message only
//  in_type     in   2   packet type; sampled on first beat of message only
//  in_data     in   8   payload byte
//  in_last     in   1   last byte of message
//  pkt_valid   out  1   to NoC src_valid; FIFO non-empty
//  pkt_ready   in   1   from NoC src_ready
//  packet      out  13  FIFO head: [12]=eop [11:4]=payload [3:2]=type [1:0]=dest
//  fifo_count  out  CW  current FIFO occupancy
//  drop_err    out  1   1-cycle pulse: message with dest==2'b11 dropped
//  len_err     out  1   1-cycle pulse: message exceeded MAX_LEN, truncated
// BEHAVIOUR
//  Reset values: in_ready=0 while reset==0; FIFO empty; pkt_valid=0; packet=0; fifo_count=0;
//   drop_err=0; len_err=0; state=IDLE; beat counter=0.
//  in_ready:
//   - IDLE/BODY: in_ready = !full.
//   - DROP/DISCARD: in_ready = 1, because bytes are consumed and not stored.
//  Beat = in_valid & in_ready. FIFO push and state change happen on the same clk edge as the beat.
//  State machine:
//   IDLE:
//    - Beat, in_dest==2'b11: pulse drop_err; no push. Go to DROP if !in_last, else stay IDLE.
//    - Beat, legal dest: latch dest/type; push {in_last,in_data,in_type,in_dest}; cnt=1.
//      Go to BODY if !in_last, else stay IDLE.
//   BODY:
//    - Each beat pushes {eop,in_data,latched type,latched dest}; cnt++.
//    - in_last: eop=1, go to IDLE.
//    - !in_last and cnt==MAX_LEN-1: eop=1 forced, pulse len_err, go to DISCARD.
//    - in_dest/in_type on BODY beats are ignored.
//   DROP/DISCARD: swallow beats, no push; go to IDLE on the beat with in_last.
//  Exactly one eop=1 packet per stored message; stored messages are 1..MAX_LEN packets.
//  FIFO behaviour:
//   - First-word fall-through: packet=head whenever pkt_valid.
//   - Pop on pkt_valid & pkt_ready.
//   - Push and pop in the same cycle: count unchanged.
//   - When full, in_ready=0, even if a pop occurs that cycle (no pass-through).
//   - When empty, a pushed entry appears on pkt_valid the next cycle; latency is 1 clk.
//   - Read and write pointers wrap modulo DEPTH. Order is strictly FIFO.
//  packet holds stable while pkt_valid & !pkt_ready (valid/ready hold rule).
//  Reset mid-message (reset==0 at any time):
//   - FIFO contents and any partial message are discarded; FSM returns to IDLE.
//   - The next beat after release is treated as a first beat.
// TESTING
//  1. Reset release, idle inputs -> pkt_valid=0, fifo_count=0, in_ready=1 from first clk.
//  2. 3-byte msg dest=2 type=1 data A1,A2,A3, pkt_ready=1 ->
//     packets 0x0A16, 0x0A26, 0x1A36 (eop only on last), 1 clk latency.
//  3. pkt_ready=0, push 5 single-byte msgs, DEPTH=4 ->
//     fifo_count=4, in_ready=0 after 4th; 5th held upstream; raise pkt_ready -> all 5 in order.
//  4. 2-byte msg dest=3 -> drop_err pulses once on first beat, no packets, next msg dest=0 stored.
//  5. 10-byte msg dest=1, MAX_LEN=8 -> 8 packets, 8th has eop=1;
//     len_err pulses on 8th beat; bytes 9-10 swallowed.
//  6. Assert reset after byte 2 of 4-byte msg with 2 entries queued ->
//     fifo_count=0, pkt_valid=0; post-release 1-byte msg emitted with its own dest/type.

Source files
------------

// File: rtl/noc_packetizer.sv
// Byte-stream to 13-bit NoC packet converter with destination filtering, length capping
// and a first-word fall-through output FIFO driving the src_valid/src_ready handshake.
module noc_packetizer #(
  parameter int unsigned  DEPTH   = 4,
  parameter int unsigned  MAX_LEN = 8,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_dest,
  input  logic [1:0]    in_type,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [12:0]   packet,
  output logic [CW-1:0] fifo_count,
  output logic          drop_err,
  output logic          len_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StBody, StDrop, StDiscard} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [1:0]    dest_q, dest_d;
  logic [1:0]    type_q, type_d;
  logic [12:0]   mem_q [DEPTH];
  logic [12:0]   mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        full, beat, push, pop;
  logic [12:0] push_pkt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    type_d   = type_q;
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    push     = 1'b0;
    push_pkt = '0;
    drop_err = 1'b0;
    len_err  = 1'b0;

    full      = (count_q == CW'(DEPTH));
    pkt_valid = (count_q != '0);
    // Swallowing states never store, so they accept regardless of FIFO space.
    in_ready  = reset & (((state_q == StDrop) || (state_q == StDiscard)) ? 1'b1 : !full);
    beat      = in_valid & in_ready;
    pop       = pkt_valid & pkt_ready;

    unique case (state_q)
      StIdle: begin
        if (beat) begin
          if (in_dest == 2'b11) begin
            drop_err = 1'b1;
            if (!in_last) state_d = StDrop;
          end else begin
            dest_d   = in_dest;
            type_d   = in_type;
            push     = 1'b1;
            push_pkt = {in_last, in_data, in_type, in_dest};
            cnt_d    = LW'(1);
            if (!in_last) state_d = StBody;
          end
        end
      end
      StBody: begin
        if (beat) begin
          push     = 1'b1;
          push_pkt = {1'b0, in_data, type_q, dest_q};
          cnt_d    = cnt_q + 1'b1;
          if (in_last) begin
            push_pkt[12] = 1'b1;
            cnt_d        = '0;
            state_d      = StIdle;
          end else if (cnt_q == LW'(MAX_LEN - 1)) begin
            push_pkt[12] = 1'b1;
            len_err      = 1'b1;
            cnt_d        = '0;
            state_d      = StDiscard;
          end
        end
      end
      StDrop, StDiscard: begin
        if (beat && in_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      mem_d[wptr_q] = push_pkt;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);

    packet     = pkt_valid ? mem_q[rptr_q] : '0;
    fifo_count = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dest_q  <= '0;
      type_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      type_q  <= type_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed scenarios plus random traffic, all checked against a
// message-level reference model holding expected packets in a queue.
module tb_noc_packetizer;

  localparam int DEPTH   = 4;
  localparam int MAX_LEN = 8;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_dest;
  logic [1:0]    in_type;
  logic [7:0]    in_data;
  logic          in_last;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [12:0]   packet;
  logic [CW-1:0] fifo_count;
  logic          drop_err;
  logic          len_err;

  noc_packetizer #(
    .DEPTH  (DEPTH),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_type   (in_type),
    .in_data   (in_data),
    .in_last   (in_last),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .packet    (packet),
    .fifo_count(fifo_count),
    .drop_err  (drop_err),
    .len_err   (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected FIFO contents and message progress.
  logic [12:0] exp_q[$];
  int          pos;   // bytes stored so far in the current message (0 = next is a first beat)
  bit          skip;  // swallowing the rest of a dropped or truncated message
  logic [1:0]  ldest, ltype;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pos  = 0;
    skip = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model and clock.
  task automatic step(input bit v, input logic [1:0] d, input logic [1:0] t,
                      input logic [7:0] data, input bit last, input bit prdy, output bit acc);
    bit          e_rdy, e_drop, e_len, do_push, eop;
    logic [12:0] p;
    in_valid  = v;
    in_dest   = d;
    in_type   = t;
    in_data   = data;
    in_last   = last;
    pkt_ready = prdy;
    #1;
    e_rdy   = skip || (exp_q.size() < DEPTH);
    acc     = v && e_rdy;
    e_drop  = 0;
    e_len   = 0;
    do_push = 0;
    p       = '0;
    check("in_ready", 16'(in_ready), 16'(e_rdy));
    check("pkt_valid", 16'(pkt_valid), 16'(exp_q.size() > 0));
    check("packet", 16'(packet), (exp_q.size() > 0) ? 16'(exp_q[0]) : 16'h0);
    check("fifo_count", 16'(fifo_count), 16'(exp_q.size()));
    if (acc) begin
      if (skip) begin
        if (last) skip = 0;
      end else if (pos == 0) begin
        if (d == 2'b11) begin
          e_drop = 1;
          skip   = !last;
        end else begin
          ldest   = d;
          ltype   = t;
          do_push = 1;
          p       = {last, data, t, d};
          pos     = last ? 0 : 1;
        end
      end else begin
        pos++;
        eop     = last || (pos == MAX_LEN);
        do_push = 1;
        p       = {eop, data, ltype, ldest};
        if (eop) begin
          if (!last) begin
            e_len = 1;
            skip  = 1;
          end
          pos = 0;
        end
      end
    end
    check("drop_err", 16'(drop_err), 16'(e_drop));
    check("len_err", 16'(len_err), 16'(e_len));
    if (prdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(p);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [1:0] t, input logic [7:0] data,
                      input bit last, input bit prdy);
    bit acc = 0;
    for (int i = 0; i < 16 && !acc; i++) step(1, d, t, data, last, prdy, acc);
    check("send_accept", 16'(acc), 16'h1);
  endtask

  task automatic idle(input int n, input bit prdy);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 2'd0, 2'd0, 8'h00, 0, prdy, acc);
  endtask

  task automatic do_reset();
    in_valid  = 0;
    pkt_ready = 0;
    reset     = 0;
    #1;
    check("rst_in_ready", 16'(in_ready), 16'h0);
    check("rst_pkt_valid", 16'(pkt_valid), 16'h0);
    check("rst_fifo_count", 16'(fifo_count), 16'h0);
    check("rst_packet", 16'(packet), 16'h0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1;
    #1;
  endtask

  initial begin
    bit acc;
    reset     = 0;
    in_valid  = 0;
    in_dest   = 0;
    in_type   = 0;
    in_data   = 0;
    in_last   = 0;
    pkt_ready = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Ready straight out of reset
    check("t1_in_ready", 16'(in_ready), 16'h1);
    check("t1_fifo_count", 16'(fifo_count), 16'h0);
    idle(2, 1);

    // 3-byte message, fixed expected encodings
    send(2'd2, 2'd1, 8'hA1, 0, 1);
    check("t2_pkt0", 16'(packet), 16'h0A16);
    send(2'd2, 2'd1, 8'hA2, 0, 1);
    check("t2_pkt1", 16'(packet), 16'h0A26);
    send(2'd2, 2'd1, 8'hA3, 1, 1);
    check("t2_pkt2", 16'(packet), 16'h1A36);
    idle(2, 1);

    // Fill FIFO with stalled sink, then release
    for (int i = 0; i < 4; i++) send(2'd0, 2'(i), 8'(8'h10 + i), 1, 0);
    check("t3_count_full", 16'(fifo_count), 16'(DEPTH));
    check("t3_in_ready_full", 16'(in_ready), 16'h0);
    step(1, 2'd1, 2'd0, 8'h14, 1, 0, acc);
    check("t3_held", 16'(acc), 16'h0);
    send(2'd1, 2'd0, 8'h14, 1, 1);
    idle(6, 1);

    // Illegal destination dropped, next message stored
    send(2'd3, 2'd0, 8'h55, 0, 1);
    send(2'd3, 2'd0, 8'h56, 1, 1);
    send(2'd0, 2'd2, 8'h77, 1, 1);
    check("t4_pkt", 16'(packet), 16'h1778);
    idle(3, 1);

    // Over-length message truncated at MAX_LEN
    for (int i = 0; i < 10; i++) send(2'd1, 2'd3, 8'(8'hC0 + i), i == 9, 1);
    idle(3, 1);

    // Reset in the middle of a message with entries queued
    send(2'd1, 2'd1, 8'hD0, 0, 0);
    send(2'd1, 2'd1, 8'hD1, 0, 0);
    check("t6_count_before", 16'(fifo_count), 16'h2);
    do_reset();
    send(2'd1, 2'd2, 8'hE5, 1, 0);
    check("t6_pkt", 16'(packet), 16'h1E59);
    idle(2, 1);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7, acc);
    end
    idle(8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
